// File: rtl/xip_apb_cache.sv
// Read-only direct-mapped word cache sitting on the APB path in front of the
// SPI/XIP flash controller. Flash reads are looked up locally and filled on a
// miss. Flash writes are rejected with an error. All other traffic is bridged
// downstream unchanged. Every upstream/downstream output is registered.
module xip_apb_cache #(
   parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
   parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
   parameter int unsigned IDX_W      = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic [31:0] out_paddr,
   output logic        out_psel,
   output logic        out_penable,
   output logic [2:0]  out_pprot,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   input  logic        out_pready,
   input  logic [31:0] out_prdata,
   input  logic        out_pslverr,
   input  logic        flush,
   output logic        perf_hit,
   output logic        perf_miss
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam int unsigned TAG_W   = 26 - IDX_W;

   typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_e;

   state_e            state_q, state_d;
   logic [31:0]       out_paddr_q, out_paddr_d;
   logic              out_psel_q, out_psel_d;
   logic              out_penable_q, out_penable_d;
   logic [2:0]        out_pprot_q, out_pprot_d;
   logic              out_pwrite_q, out_pwrite_d;
   logic [31:0]       out_pwdata_q, out_pwdata_d;
   logic [3:0]        out_pstrb_q, out_pstrb_d;
   logic              in_pready_q, in_pready_d;
   logic [31:0]       in_prdata_q, in_prdata_d;
   logic              in_pslverr_q, in_pslverr_d;
   logic              perf_hit_q, perf_hit_d;
   logic              perf_miss_q, perf_miss_d;
   logic              fill_q, fill_d;      // in-flight transfer is a flash fill
   logic              kill_q, kill_d;      // flush seen while the fill was in flight
   logic              fill_we;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q  [ENTRIES];
   logic [31:0]        data_q [ENTRIES];

   logic               is_flash;
   logic [IDX_W-1:0]   lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;
   logic [IDX_W-1:0]   fill_idx;
   logic [TAG_W-1:0]   fill_tag;

   assign is_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
   assign lk_idx   = in_paddr[IDX_W+1:2];
   assign lk_tag   = in_paddr[27:IDX_W+2];
   assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   // The held downstream address of a fill is already word aligned.
   assign fill_idx = out_paddr_q[IDX_W+1:2];
   assign fill_tag = out_paddr_q[27:IDX_W+2];

   // Next-state and registered-output decisions for the bridge FSM.
   always_comb begin
      state_d       = state_q;
      out_paddr_d   = out_paddr_q;
      out_psel_d    = out_psel_q;
      out_penable_d = out_penable_q;
      out_pprot_d   = out_pprot_q;
      out_pwrite_d  = out_pwrite_q;
      out_pwdata_d  = out_pwdata_q;
      out_pstrb_d   = out_pstrb_q;
      in_pready_d   = 1'b0;
      in_prdata_d   = in_prdata_q;
      in_pslverr_d  = in_pslverr_q;
      perf_hit_d    = 1'b0;
      perf_miss_d   = 1'b0;
      fill_d        = fill_q;
      kill_d        = kill_q;
      fill_we       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_psel && in_penable) begin
               if (is_flash && !in_pwrite && lk_hit && !flush) begin
                  in_prdata_d  = data_q[lk_idx];
                  in_pslverr_d = 1'b0;
                  in_pready_d  = 1'b1;
                  perf_hit_d   = 1'b1;
                  state_d      = RESP;
               end else if (is_flash && in_pwrite) begin
                  in_prdata_d  = '0;
                  in_pslverr_d = 1'b1;
                  in_pready_d  = 1'b1;
                  state_d      = RESP;
               end else begin
                  out_paddr_d   = is_flash ? {in_paddr[31:2], 2'b00} : in_paddr;
                  out_pwrite_d  = is_flash ? 1'b0 : in_pwrite;
                  out_pprot_d   = in_pprot;
                  out_pwdata_d  = in_pwdata;
                  out_pstrb_d   = in_pstrb;
                  out_psel_d    = 1'b1;
                  out_penable_d = 1'b0;
                  perf_miss_d   = is_flash;
                  fill_d        = is_flash;
                  kill_d        = 1'b0;
                  state_d       = M_SETUP;
               end
            end
         end
         M_SETUP: begin
            out_penable_d = 1'b1;
            if (flush) kill_d = 1'b1;
            state_d = M_ACCESS;
         end
         M_ACCESS: begin
            if (flush) kill_d = 1'b1;
            if (out_pready) begin
               in_prdata_d   = out_prdata;
               in_pslverr_d  = out_pslverr;
               in_pready_d   = 1'b1;
               out_psel_d    = 1'b0;
               out_penable_d = 1'b0;
               // A flush in the completing cycle also blocks the fill.
               fill_we       = fill_q && !out_pslverr && !kill_q && !flush;
               state_d       = RESP;
            end
         end
         RESP: begin
            fill_d  = 1'b0;
            kill_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and all registered outputs; cleared by the async reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         out_paddr_q   <= '0;
         out_psel_q    <= 1'b0;
         out_penable_q <= 1'b0;
         out_pprot_q   <= '0;
         out_pwrite_q  <= 1'b0;
         out_pwdata_q  <= '0;
         out_pstrb_q   <= '0;
         in_pready_q   <= 1'b0;
         in_prdata_q   <= '0;
         in_pslverr_q  <= 1'b0;
         perf_hit_q    <= 1'b0;
         perf_miss_q   <= 1'b0;
         fill_q        <= 1'b0;
         kill_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_paddr_q   <= out_paddr_d;
         out_psel_q    <= out_psel_d;
         out_penable_q <= out_penable_d;
         out_pprot_q   <= out_pprot_d;
         out_pwrite_q  <= out_pwrite_d;
         out_pwdata_q  <= out_pwdata_d;
         out_pstrb_q   <= out_pstrb_d;
         in_pready_q   <= in_pready_d;
         in_prdata_q   <= in_prdata_d;
         in_pslverr_q  <= in_pslverr_d;
         perf_hit_q    <= perf_hit_d;
         perf_miss_q   <= perf_miss_d;
         fill_q        <= fill_d;
         kill_q        <= kill_d;
      end
   end

   // Valid bits: flush wins over a fill landing on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill_we) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data arrays are not reset; valid bits qualify their contents.
   always_ff @(posedge clock) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= out_prdata;
      end
   end

   assign out_paddr   = out_paddr_q;
   assign out_psel    = out_psel_q;
   assign out_penable = out_penable_q;
   assign out_pprot   = out_pprot_q;
   assign out_pwrite  = out_pwrite_q;
   assign out_pwdata  = out_pwdata_q;
   assign out_pstrb   = out_pstrb_q;
   assign in_pready   = in_pready_q;
   assign in_prdata   = in_prdata_q;
   assign in_pslverr  = in_pslverr_q;
   assign perf_hit    = perf_hit_q;
   assign perf_miss   = perf_miss_q;

endmodule

// File: tb/tb_xip_apb_cache.sv
// Self-checking bench for xip_apb_cache: directed scenarios plus a randomized
// run, all checked against a behavioural cache/flash model held in the bench.
module tb_xip_apb_cache;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0;
   logic        in_penable = 1'b0;
   logic [2:0]  in_pprot = '0;
   logic        in_pwrite = 1'b0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = '0;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic [31:0] out_paddr;
   logic        out_psel;
   logic        out_penable;
   logic [2:0]  out_pprot;
   logic        out_pwrite;
   logic [31:0] out_pwdata;
   logic [3:0]  out_pstrb;
   logic        out_pready = 1'b0;
   logic [31:0] out_prdata = '0;
   logic        out_pslverr = 1'b0;
   logic        flush = 1'b0;
   logic        perf_hit;
   logic        perf_miss;

   int checks = 0;
   int failures = 0;

   // downstream slave configuration and transfer log
   int          ds_lat = 0;
   logic        ds_err = 1'b0;
   logic        ds_ovr_en = 1'b0;
   logic [31:0] ds_ovr = '0;
   int          ds_count = 0;
   int          psel_cycles = 0;
   logic [31:0] ds_addr, ds_wdata, ds_rdata;
   logic [3:0]  ds_strb;
   logic        ds_write;
   logic [2:0]  ds_prot;

   // reference cache: what a direct-mapped 16 x 1-word cache should hold
   logic        mvalid [16];
   logic [21:0] mtag   [16];
   logic [31:0] mdata  [16];

   xip_apb_cache #(
      .FLASH_BASE(32'h3000_0000),
      .FLASH_END (32'h3fff_ffff),
      .IDX_W     (4)
   ) dut (
      .clock(clock), .reset(reset),
      .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
      .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
      .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
      .in_pslverr(in_pslverr),
      .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
      .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
      .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
      .out_pslverr(out_pslverr),
      .flush(flush), .perf_hit(perf_hit), .perf_miss(perf_miss)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return w ^ 32'h5A5A_C3C3 ^ {w[15:0], w[31:16]};
   endfunction

   function automatic logic is_flash(input logic [31:0] a);
      return (a >= 32'h3000_0000) && (a <= 32'h3fff_ffff);
   endfunction

   function automatic logic m_hit(input logic [31:0] a);
      return mvalid[a[5:2]] && (mtag[a[5:2]] == a[27:6]);
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
   endfunction

   // Downstream APB slave: ready after ds_lat extra access cycles.
   initial begin : slave
      int wait_cnt;
      wait_cnt = 0;
      forever begin
         @(negedge clock);
         out_pready = 1'b0;
         if (out_psel) psel_cycles++;
         if (reset && out_psel && out_penable) begin
            if (wait_cnt >= ds_lat) begin
               out_pready  = 1'b1;
               out_prdata  = ds_ovr_en ? ds_ovr : mem_word(out_paddr);
               out_pslverr = ds_err;
               ds_count++;
               ds_addr  = out_paddr;  ds_wdata = out_pwdata; ds_strb = out_pstrb;
               ds_write = out_pwrite; ds_prot  = out_pprot;  ds_rdata = out_prdata;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // One upstream APB transfer; cyc counts cycles with cyc==1 the first access cycle.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       output logic [31:0] rdata, output logic err, output int cyc,
                       output logic hit, output logic miss);
      in_paddr = addr; in_pwrite = wr; in_pwdata = wdata; in_pstrb = strb; in_pprot = prot;
      in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clock);
      in_penable = 1'b1;
      cyc = 1; hit = 1'b0; miss = 1'b0;
      while (1) begin
         @(negedge clock);
         cyc++;
         hit  = hit | perf_hit;
         miss = miss | perf_miss;
         if (in_pready) break;
         if (cyc > 400) begin
            checks++; failures++;
            $display("FAIL xfer_timeout addr=%h got no in_pready within 400 cycles, required ready", addr);
            break;
         end
      end
      rdata = in_prdata; err = in_pslverr;
      in_psel = 1'b0; in_penable = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      m_clear();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      m_clear();
      repeat (3) @(negedge clock);
      #1;
      checks++; if ({in_pready, in_pslverr, out_psel, out_penable, out_pwrite, perf_hit, perf_miss} !== 7'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b required=0000000",
            {in_pready, in_pslverr, out_psel, out_penable, out_pwrite, perf_hit, perf_miss}); end
      checks++; if (in_prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h required=0", in_prdata); end
      checks++; if ({out_paddr, out_pwdata, out_pstrb, out_pprot} !== 71'h0) begin
         failures++; $display("FAIL reset_bus got=%h/%h/%h/%h required=0", out_paddr, out_pwdata, out_pstrb, out_pprot); end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_miss_hit();
      logic [31:0] rd; logic er, h, m; int cyc, n0;
      ds_lat = 20; ds_err = 1'b0; ds_ovr_en = 1'b1; ds_ovr = 32'hDEAD_BEEF;
      n0 = ds_count;
      xfer(32'h3000_0010, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      ds_ovr_en = 1'b0;
      mvalid[4] = 1'b1; mtag[4] = 22'h0; mdata[4] = 32'hDEAD_BEEF;
      checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL miss_rdata got=%h required=deadbeef", rd); end
      checks++; if ({er, h, m} !== 3'b001) begin failures++; $display("FAIL miss_flags err/hit/miss got=%b required=001", {er, h, m}); end
      checks++; if (ds_count - n0 !== 1 || ds_addr !== 32'h3000_0010 || ds_write !== 1'b0) begin
         failures++; $display("FAIL miss_downstream got n=%0d addr=%h wr=%b required n=1 addr=30000010 wr=0", ds_count - n0, ds_addr, ds_write); end
      checks++; if (cyc !== 20 + 4) begin failures++; $display("FAIL miss_latency got=%0d required=%0d", cyc, 24); end
      n0 = ds_count;
      xfer(32'h3000_0010, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hit_rdata got=%h required=deadbeef", rd); end
      checks++; if ({er, h, m} !== 3'b010) begin failures++; $display("FAIL hit_flags err/hit/miss got=%b required=010", {er, h, m}); end
      checks++; if (ds_count - n0 !== 0) begin failures++; $display("FAIL hit_downstream got n=%0d required n=0", ds_count - n0); end
      checks++; if (cyc !== 2) begin failures++; $display("FAIL hit_latency got=%0d required=2", cyc); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; logic er, h, m; int cyc, n0;
      ds_lat = 3;
      xfer(32'h3000_0012, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if (rd !== 32'hDEAD_BEEF || h !== 1'b1) begin failures++; $display("FAIL unaligned_hit got=%h hit=%b required=deadbeef hit=1", rd, h); end
      n0 = ds_count;
      xfer(32'h3000_0050, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if (m !== 1'b1 || ds_count - n0 !== 1 || ds_addr !== 32'h3000_0050 || rd !== mem_word(32'h3000_0050)) begin
         failures++; $display("FAIL conflict_miss got miss=%b n=%0d addr=%h rd=%h required miss=1 n=1 addr=30000050 rd=%h",
            m, ds_count - n0, ds_addr, rd, mem_word(32'h3000_0050)); end
      mvalid[4] = 1'b1; mtag[4] = 22'h1; mdata[4] = mem_word(32'h3000_0050);
      xfer(32'h3000_0010, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if ({h, m} !== 2'b01 || rd !== mem_word(32'h3000_0010)) begin
         failures++; $display("FAIL evicted_miss got hit/miss=%b rd=%h required=01 rd=%h", {h, m}, rd, mem_word(32'h3000_0010)); end
      mvalid[4] = 1'b1; mtag[4] = 22'h0; mdata[4] = mem_word(32'h3000_0010);
   endtask

   task automatic test_writes();
      logic [31:0] rd; logic er, h, m; int cyc, p0;
      ds_lat = 2;
      p0 = psel_cycles;
      xfer(32'h3000_0000, 1'b1, 32'h55, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if (er !== 1'b1 || psel_cycles - p0 !== 0 || cyc !== 2) begin
         failures++; $display("FAIL flash_write got err=%b psel_cycles=%0d cyc=%0d required err=1 psel_cycles=0 cyc=2", er, psel_cycles - p0, cyc); end
      xfer(32'h1000_1004, 1'b1, 32'h12, 4'b0101, 3'b010, rd, er, cyc, h, m);
      checks++; if ({ds_addr, ds_wdata, ds_strb, ds_write, ds_prot} !== {32'h1000_1004, 32'h12, 4'b0101, 1'b1, 3'b010}) begin
         failures++; $display("FAIL passthru_write got addr=%h wdata=%h strb=%b wr=%b prot=%b required 10001004/12/0101/1/010",
            ds_addr, ds_wdata, ds_strb, ds_write, ds_prot); end
      checks++; if ({er, h, m} !== 3'b000 || cyc !== 2 + 4) begin
         failures++; $display("FAIL passthru_flags got err/hit/miss=%b cyc=%0d required=000 cyc=6", {er, h, m}, cyc); end
   endtask

   task automatic test_flush_inflight();
      logic [31:0] rd; logic er, h, m; int cyc;
      ds_lat = 10;
      fork
         xfer(32'h3000_0104, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
         begin
            int n;
            n = 0;
            while (!out_penable && n < 200) begin @(negedge clock); n++; end
            flush = 1'b1;
            @(negedge clock);
            flush = 1'b0;
         end
      join
      m_clear();
      checks++; if (rd !== mem_word(32'h3000_0104) || m !== 1'b1) begin
         failures++; $display("FAIL killed_fill_data got=%h miss=%b required=%h miss=1", rd, m, mem_word(32'h3000_0104)); end
      xfer(32'h3000_0104, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if ({h, m} !== 2'b01) begin failures++; $display("FAIL killed_fill_reread got hit/miss=%b required=01", {h, m}); end
      mvalid[1] = 1'b1; mtag[1] = 22'h4; mdata[1] = rd;
   endtask

   task automatic test_flush_all();
      logic [31:0] rd; logic er, h, m; int cyc, hits, misses;
      ds_lat = 1;
      for (int i = 0; i < 4; i++) xfer(32'h3000_0200 + 32'(i * 4), 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         xfer(32'h3000_0200 + 32'(i * 4), 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
         if (h) hits++;
      end
      checks++; if (hits !== 4) begin failures++; $display("FAIL prefill_hits got=%0d required=4", hits); end
      do_flush();
      misses = 0;
      for (int i = 0; i < 4; i++) begin
         xfer(32'h3000_0200 + 32'(i * 4), 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
         if (m && !h) misses++;
         mvalid[i] = 1'b1; mtag[i] = 22'h8; mdata[i] = rd;
      end
      checks++; if (misses !== 4) begin failures++; $display("FAIL flush_all_misses got=%0d required=4", misses); end
   endtask

   task automatic test_error();
      logic [31:0] rd; logic er, h, m; int cyc;
      ds_lat = 4; ds_err = 1'b1;
      xfer(32'h3000_0308, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      ds_err = 1'b0;
      checks++; if ({er, m} !== 2'b11) begin failures++; $display("FAIL err_pass got err/miss=%b required=11", {er, m}); end
      xfer(32'h3000_0308, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if ({er, h, m} !== 3'b001) begin failures++; $display("FAIL err_not_cached got err/hit/miss=%b required=001", {er, h, m}); end
      mvalid[2] = 1'b1; mtag[2] = 22'hC; mdata[2] = rd;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er, h, m; int cyc, n;
      xfer(32'h3000_0308, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if (h !== 1'b1) begin failures++; $display("FAIL premid_hit got=%b required=1", h); end
      ds_lat = 50;
      in_paddr = 32'h3000_0400; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clock);
      in_penable = 1'b1;
      n = 0;
      while (!out_penable && n < 20) begin @(negedge clock); n++; end
      checks++; if (out_penable !== 1'b1) begin failures++; $display("FAIL mid_reach_access got penable=%b required=1", out_penable); end
      reset = 1'b0;
      #1;
      checks++; if ({out_psel, out_penable, in_pready, perf_hit, perf_miss, out_paddr} !== 37'h0) begin
         failures++; $display("FAIL mid_reset_outputs got psel=%b pen=%b rdy=%b hit=%b miss=%b addr=%h required all 0",
            out_psel, out_penable, in_pready, perf_hit, perf_miss, out_paddr); end
      in_psel = 1'b0; in_penable = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      m_clear();
      @(negedge clock);
      ds_lat = 2;
      xfer(32'h3000_0308, 1'b0, '0, 4'hF, 3'b000, rd, er, cyc, h, m);
      checks++; if ({h, m} !== 2'b01) begin failures++; $display("FAIL post_reset_miss got hit/miss=%b required=01", {h, m}); end
      mvalid[2] = 1'b1; mtag[2] = 22'hC; mdata[2] = rd;
   endtask

   task automatic test_random();
      logic [31:0] a, rd, wd, exp_rd, exp_addr; logic er, h, m, wr, fl, exp_er, exp_h, exp_m;
      logic [3:0] sb; logic [2:0] pr; int cyc, n0, kind, exp_cyc, exp_n;
      for (int t = 0; t < 150; t++) begin
         kind = $urandom_range(0, 9);
         wd = $urandom; sb = 4'($urandom); pr = 3'($urandom);
         ds_lat = $urandom_range(0, 5);
         ds_err = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 19) == 0) do_flush();
         if (kind <= 7) begin
            if ($urandom_range(0, 15) == 0) a = 32'h3FFF_FFFC | 32'($urandom_range(0, 3));
            else a = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            wr = (kind == 7);
         end else begin
            case ($urandom_range(0, 3))
               0: a = 32'h2FFF_FFFC;
               1: a = 32'h4000_0000;
               default: a = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
            endcase
            wr = (kind == 9);
         end
         fl = is_flash(a);
         exp_addr = fl ? {a[31:2], 2'b00} : a;
         exp_h = 1'b0; exp_m = 1'b0; exp_er = ds_err; exp_rd = mem_word(a);
         exp_cyc = ds_lat + 4; exp_n = 1;
         if (fl && wr) begin
            exp_er = 1'b1; exp_cyc = 2; exp_n = 0;
         end else if (fl && m_hit(a)) begin
            exp_h = 1'b1; exp_er = 1'b0; exp_rd = mdata[a[5:2]]; exp_cyc = 2; exp_n = 0;
         end else if (fl) begin
            exp_m = 1'b1;
         end
         n0 = ds_count;
         xfer(a, wr, wd, sb, pr, rd, er, cyc, h, m);
         checks++; if ({er, h, m} !== {exp_er, exp_h, exp_m}) begin
            failures++; $display("FAIL rnd_flags t=%0d addr=%h wr=%b got err/hit/miss=%b required=%b", t, a, wr, {er, h, m}, {exp_er, exp_h, exp_m}); end
         checks++; if (cyc !== exp_cyc) begin
            failures++; $display("FAIL rnd_latency t=%0d addr=%h got=%0d required=%0d", t, a, cyc, exp_cyc); end
         checks++; if (ds_count - n0 !== exp_n) begin
            failures++; $display("FAIL rnd_ds_count t=%0d addr=%h got=%0d required=%0d", t, a, ds_count - n0, exp_n); end
         if (!wr) begin
            checks++; if (rd !== exp_rd) begin
               failures++; $display("FAIL rnd_rdata t=%0d addr=%h got=%h required=%h", t, a, rd, exp_rd); end
         end
         if (exp_n == 1) begin
            checks++; if ({ds_addr, ds_write, ds_prot, ds_wdata, ds_strb} !== {exp_addr, wr, pr, wd, sb}) begin
               failures++; $display("FAIL rnd_ds_fields t=%0d got addr=%h wr=%b prot=%b wdata=%h strb=%b required %h/%b/%b/%h/%b",
                  t, ds_addr, ds_write, ds_prot, ds_wdata, ds_strb, exp_addr, wr, pr, wd, sb); end
         end
         if (fl && !wr && exp_m && !ds_err) begin
            mvalid[a[5:2]] = 1'b1; mtag[a[5:2]] = a[27:6]; mdata[a[5:2]] = mem_word(a);
         end
      end
      ds_err = 1'b0;
   endtask

   initial begin
      test_reset();
      test_miss_hit();
      test_alias();
      test_writes();
      test_flush_inflight();
      test_flush_all();
      test_error();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xip_apb_cache.md
Name: xip_apb_cache

Overview:
- Read-only, direct-mapped word cache on the APB path between the SoC crossbar and the SPI/XIP flash controller; the controller sits downstream on the APB master port.
- Absorbs repeated instruction fetches from flash, avoiding the ~100+-cycle SPI transfer on every hit.
- Non-flash transactions pass through unchanged.
- Writes into the flash window are rejected locally.

Parameters:
- FLASH_BASE, 32'h3000_0000, first byte address of the cached flash window.
- FLASH_END, 32'h3fff_ffff, last byte address of the window (inclusive).
- IDX_W, 4, index width; the cache holds 2^IDX_W one-word entries.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- in_paddr  in  32  upstream APB address.
- in_psel  in  1  upstream select.
- in_penable  in  1  upstream enable.
- in_pprot  in  3  upstream protection; forwarded as-is.
- in_pwrite  in  1  upstream write.
- in_pwdata  in  32  upstream write data.
- in_pstrb  in  4  upstream strobes.
- in_pready  out  1  upstream ready; registered.
- in_prdata  out  32  upstream read data; registered.
- in_pslverr  out  1  upstream error; registered.
- out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb  out  32/1/1/3/1/32/4  downstream APB master; all registered.
- out_pready  in  1  downstream ready.
- out_prdata  in  32  downstream read data.
- out_pslverr  in  1  downstream error.
- flush  in  1  synchronous invalidate-all pulse (fence.i).
- perf_hit  out  1  one-cycle pulse per cached hit.
- perf_miss  out  1  one-cycle pulse per flash read miss.

Behaviour:
- Reset (async, reset=0): all outputs 0, all valid bits 0, state IDLE. Tag and data arrays are not reset. Reset mid-transaction abandons it silently.
- Address decode:
  - is_flash = FLASH_BASE <= in_paddr <= FLASH_END.
  - Entry index = in_paddr[IDX_W+1:2].
  - Tag = in_paddr[27:IDX_W+2].
  - Downstream flash reads always use a word-aligned address {in_paddr[31:2],2'b00}.
- State machine: IDLE, M_SETUP, M_ACCESS, RESP.
- IDLE: acts on in_psel && in_penable (access phase). Decision:
  - Flash read, valid && tag match, flush=0 → capture data, pulse perf_hit, go to RESP.
  - Flash write → in_pslverr=1 in RESP; nothing forwarded.
  - Otherwise (flash miss, or any non-flash access) → load out_* from in_* (flash-miss address word-aligned, out_pwrite=0), set out_psel=1, go to M_SETUP. perf_miss pulses for flash misses only.
- M_SETUP: one cycle with out_psel=1, out_penable=0. Then out_penable=1 and go to M_ACCESS.
- M_ACCESS: hold all out_* stable until out_pready=1. On out_pready:
  - Capture out_prdata and out_pslverr.
  - Drop out_psel and out_penable in the next cycle.
  - Go to RESP.
  - If this was a flash miss and out_pslverr=0 and no flush occurred since the miss was issued: write data/tag and set valid.
- RESP: in_pready=1 for exactly one cycle with in_prdata/in_pslverr valid, then IDLE. in_pready is 0 in all other states.
- Latency:
  - Hit: in_pready in the 2nd access-phase cycle.
  - Miss/passthrough: downstream latency + 3 cycles.
- Flush:
  - Clears all valid bits at the next edge.
  - An IDLE lookup in the same cycle as flush is treated as a miss.
  - A flush during M_SETUP/M_ACCESS sets a sticky kill flag; the in-flight fill returns data upstream but does not validate the entry. The kill flag clears in RESP.
- Errors: downstream errors are passed upstream unchanged, and an erroring flash read is never cached.
- Upstream deasserts in_psel mid-transaction (protocol violation): the downstream transfer is still completed; RESP drives in_pready for one cycle regardless; there is no hang.
- Back-to-back: a new access phase is accepted in the cycle after RESP (IDLE); there is no pipelining.

Test Plan:
- Reset, then read 0x3000_0010 with downstream ready after 20 cycles, data 0xDEADBEEF → one downstream read at 0x3000_0010, perf_miss=1, upstream in_prdata=0xDEADBEEF. Repeat the read → no downstream activity, perf_hit=1, in_pready in the 2nd access cycle.
- Read 0x3000_0012 after the above → hit, returns 0xDEADBEEF. Read 0x3000_0050 (same index, different tag) → miss, refill. Reread 0x3000_0010 → miss.
- Write 0x3000_0000 → in_pslverr=1, out_psel never asserts. Write 0x1000_1004 data 0x12 → forwarded with identical paddr/pwdata/pstrb/pwrite=1.
- Flash read miss with flush pulsed during M_ACCESS → data returned upstream; the same read again misses. Flush while entries are valid → all subsequent reads miss.
- Downstream returns out_pslverr=1 on a flash read → in_pslverr=1, next read of the same address misses.
- Assert reset for one cycle during M_ACCESS → all outputs 0 immediately. After release, a read to a previously cached address misses.
